// File: rtl/dds_pkg.sv
// Shared DDS types and helpers.
// Holds the DAC serialiser FSM state type and the frame width helper used to
// size the serial frame (command prefix followed by one waveform sample).
package dds_pkg;

  // Serialiser states: wait for a sample, chip-select setup, clocking bits out,
  // chip-select hold after the last bit, then a deselected gap before the next frame.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } dac_state_t;

  // Number of bits in one serial frame.
  function automatic int unsigned frame_bits(input int unsigned cmd_w,
                                             input int unsigned data_w);
    return cmd_w + data_w;
  endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// SPI half-period tick generator.
// Counts SCLK_DIV cycles while enabled and pulses o_tick on the last cycle of
// each period, reloading at the same time. While disabled the counter parks at
// zero so the first period after enabling is a full SCLK_DIV cycles.
// Ports:
//   i_clk  - system clock, rising edge
//   i_rst  - synchronous active-high reset
//   i_en   - count enable
//   o_tick - one-cycle pulse at the end of every SCLK_DIV-cycle period
module sclk_tick_gen #(
  parameter int unsigned SCLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [7:0] LP_LAST = 8'(SCLK_DIV - 1);

  logic [7:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LP_LAST);

  // Period counter: runs while enabled, reloads on each tick, held at zero when disabled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= 8'd0;
    end else if (!i_en || o_tick) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/dac_spi_out.sv
// DAC SPI output serialiser.
// Takes one waveform sample per handshake, prefixes it with a constant command
// and shifts the frame out MSB first on an idle-low SPI clock. dac_mosi changes
// only on falling dac_sclk edges so the DAC can sample on rising edges.
// Frame timing (D = SCLK_DIV): D cycles chip-select setup, 2*FRAME_BITS half
// periods of D cycles, D cycles hold, D cycles deselected gap.
// Optional feature: define DAC_OVERRUN_CNT_EN to add overrun_cnt, a saturating
// 16-bit count of cycles where a sample was offered while the block was busy.
// Ports:
//   sys_clk      - system clock, all logic on its rising edge
//   rst          - synchronous active-high reset
//   sample_in    - waveform sample to transmit
//   sample_valid - sample_in is valid
//   sample_ready - block accepts a sample this cycle (only in IDLE)
//   dac_sclk     - SPI clock, idle low
//   dac_mosi     - serial data, MSB first, low while deselected
//   dac_cs_n     - active-low chip select
//   busy         - high whenever the FSM is not IDLE
//   overrun_cnt  - (DAC_OVERRUN_CNT_EN only) saturating overrun cycle count
module dac_spi_out
  import dds_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = 16,
  parameter int unsigned            CMD_WIDTH  = 8,
  parameter logic [CMD_WIDTH-1:0]   CMD_VALUE  = 8'h30,
  parameter int unsigned            SCLK_DIV   = 2
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  dac_sclk,
  output logic                  dac_mosi,
  output logic                  dac_cs_n,
  output logic                  busy
`ifdef DAC_OVERRUN_CNT_EN
  ,
  output logic [15:0]           overrun_cnt
`endif
);

  localparam int unsigned FRAME_BITS = frame_bits(CMD_WIDTH, DATA_WIDTH);
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS) + 1;
  localparam logic [CNT_W-1:0] LP_LAST_BIT = CNT_W'(FRAME_BITS - 1);

  dac_state_t              r_state;
  dac_state_t              w_state_nxt;
  // The shift register MSB is the bit on the wire, so clearing it forces mosi low.
  logic [FRAME_BITS-1:0]   r_shift;
  logic [FRAME_BITS-1:0]   w_shift_nxt;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [CNT_W-1:0]        w_bit_cnt_nxt;
  logic                    r_sclk;
  logic                    w_sclk_nxt;
  logic                    r_cs_n;
  logic                    w_cs_n_nxt;
  logic                    w_tick;
  logic                    w_ready;
  logic [FRAME_BITS-1:0]   w_frame;

  assign w_ready = (r_state == IDLE);
  assign w_frame = {CMD_VALUE, sample_in};

  sclk_tick_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_tick (
    .i_clk  (sys_clk),
    .i_rst  (rst),
    .i_en   (!w_ready),
    .o_tick (w_tick)
  );

  // Next-state and next-output logic for the serialiser FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_sclk_nxt    = r_sclk;
    w_cs_n_nxt    = r_cs_n;
    case (r_state)
      IDLE: begin
        if (sample_valid) begin
          w_state_nxt   = SETUP;
          w_shift_nxt   = w_frame;
          w_bit_cnt_nxt = {CNT_W{1'b0}};
          w_sclk_nxt    = 1'b0;
          w_cs_n_nxt    = 1'b0;
        end else begin
          w_state_nxt   = IDLE;
        end
      end
      SETUP: begin
        if (w_tick) begin
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = SETUP;
        end
      end
      SHIFT: begin
        if (w_tick) begin
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else begin
            // Falling edge: present the next bit; the last one ends the frame.
            w_sclk_nxt  = 1'b0;
            w_shift_nxt = {r_shift[FRAME_BITS-2:0], 1'b0};
            if (r_bit_cnt == LP_LAST_BIT) begin
              w_state_nxt = HOLD;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      HOLD: begin
        if (w_tick) begin
          w_state_nxt = GAP;
          w_cs_n_nxt  = 1'b1;
          w_shift_nxt = {FRAME_BITS{1'b0}};
        end else begin
          w_state_nxt = HOLD;
        end
      end
      GAP: begin
        if (w_tick) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = GAP;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_shift_nxt   = {FRAME_BITS{1'b0}};
        w_bit_cnt_nxt = {CNT_W{1'b0}};
        w_sclk_nxt    = 1'b0;
        w_cs_n_nxt    = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= {FRAME_BITS{1'b0}};
      r_bit_cnt <= {CNT_W{1'b0}};
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_sclk    <= w_sclk_nxt;
      r_cs_n    <= w_cs_n_nxt;
    end
  end

  assign sample_ready = w_ready;
  assign busy         = !w_ready;
  assign dac_sclk     = r_sclk;
  assign dac_mosi     = r_shift[FRAME_BITS-1];
  assign dac_cs_n     = r_cs_n;

`ifdef DAC_OVERRUN_CNT_EN
  logic [15:0] r_ovr_cnt;

  // Saturating count of cycles where a sample was offered but not accepted.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_ovr_cnt <= 16'd0;
    end else if (sample_valid && !w_ready && (r_ovr_cnt != 16'hFFFF)) begin
      r_ovr_cnt <= r_ovr_cnt + 16'd1;
    end
  end

  assign overrun_cnt = r_ovr_cnt;
`endif

endmodule
